// File: rtl/mem_access_unit.sv
// Load/store unit for a word-wide synchronous data RAM without byte enables.
// Loads read one word and extract/extend the addressed lane; sub-word stores
// read the word, merge the new lane in and write the whole word back.
//
// Request handshake: req is a single-cycle-qualified strobe that is taken only
// while the unit sits in IDLE (the edge where state==IDLE and req==1 accepts it);
// req in any other state is ignored. Completion is signalled by a one-cycle done
// pulse, with err raised in the same cycle when the request was rejected.
module mem_access_unit #(
  parameter int DEPTH_BITS = 5
) (
  input  logic        clock,
  input  logic        nReset,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        ramR,
  output logic        ramW,
  output logic [31:0] ramAddr,
  output logic [31:0] ramDataW,
  input  logic [31:0] ramDataR,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    CAP   = 3'd2,
    MERGE = 3'd3,
    WR    = 3'd4,
    FIN   = 3'd5
  } state_t;

  state_t      state, nxt;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [31:0] wreg_q;
  logic        rmw_q;
  logic        err_q;

  logic        accept;
  logic        illegal;
  logic        misaligned;
  logic        bad;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_val;
  logic [31:0] merged;
  logic        unused_addr;

  // High address bits alias onto the RAM; they are intentionally dropped.
  assign unused_addr = ^addr[31:DEPTH_BITS+2];

  assign state_dbg = state;
  assign accept    = (state == IDLE) && req;

  // Request classification on the live inputs, used only at accept time.
  always_comb begin
    illegal    = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (funct3[2] && we);
    misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    bad        = illegal || misaligned;
  end

  // Lane extraction/extension for loads and lane merge for sub-word stores.
  always_comb begin
    byte_v   = ramDataR[{off_q, 3'b000} +: 8];
    half_v   = off_q[1] ? ramDataR[31:16] : ramDataR[15:0];
    load_val = ramDataR;
    case (f3_q)
      3'b000:  load_val = {{24{byte_v[7]}}, byte_v};
      3'b001:  load_val = {{16{half_v[15]}}, half_v};
      3'b100:  load_val = {24'd0, byte_v};
      3'b101:  load_val = {16'd0, half_v};
      default: load_val = ramDataR;
    endcase
    merged = ramDataR;
    if (f3_q[0]) begin
      merged[{off_q[1], 4'b0000} +: 16] = wreg_q[15:0];
    end else begin
      merged[{off_q, 3'b000} +: 8] = wreg_q[7:0];
    end
  end

  // State register.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) state <= IDLE;
    else         state <= nxt;
  end

  // Next-state and Moore output decode; RAM strobes come straight from state.
  always_comb begin
    nxt      = state;
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    ramR     = 1'b0;
    ramW     = 1'b0;
    ramDataW = 32'd0;
    case (state)
      IDLE: begin
        if (req) begin
          if (bad)                     nxt = FIN;
          else if (!we)                nxt = RD;
          else if (funct3 == 3'b010)   nxt = WR;
          else                         nxt = RD;
        end
      end
      RD: begin
        busy = 1'b1;
        ramR = 1'b1;
        nxt  = rmw_q ? MERGE : CAP;
      end
      CAP: begin
        busy = 1'b1;
        nxt  = FIN;
      end
      MERGE: begin
        busy = 1'b1;
        nxt  = WR;
      end
      WR: begin
        busy     = 1'b1;
        ramW     = 1'b1;
        ramDataW = wreg_q;
        nxt      = FIN;
      end
      FIN: begin
        done = 1'b1;
        err  = err_q;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Request latches, write word, load result and RAM word index.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      f3_q    <= 3'd0;
      off_q   <= 2'd0;
      wreg_q  <= 32'd0;
      rmw_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata   <= 32'd0;
      ramAddr <= 32'd0;
    end else begin
      if (accept) begin
        f3_q    <= funct3;
        off_q   <= addr[1:0];
        wreg_q  <= wdata;
        rmw_q   <= we && !bad && (funct3 != 3'b010);
        err_q   <= bad;
        ramAddr <= {{(32-DEPTH_BITS){1'b0}}, addr[DEPTH_BITS+1:2]};
      end
      if (state == CAP)   rdata  <= load_val;
      if (state == MERGE) wreg_q <= merged;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit with a behavioural synchronous RAM.
module tb_mem_access_unit;

  logic        clock;
  logic        nReset;
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy, done, err;
  logic [31:0] rdata;
  logic        ramR, ramW;
  logic [31:0] ramAddr, ramDataW;
  logic [31:0] ramDataR;
  logic [2:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  // RAM model and preload port
  logic [31:0] mem [32];
  logic        pl_en;
  logic [4:0]  pl_idx;
  logic [31:0] pl_val;
  int          wr_count = 0;

  mem_access_unit #(.DEPTH_BITS(5)) dut (
    .clock(clock), .nReset(nReset), .req(req), .we(we), .funct3(funct3),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
    .rdata(rdata), .ramR(ramR), .ramW(ramW), .ramAddr(ramAddr),
    .ramDataW(ramDataW), .ramDataR(ramDataR), .state_dbg(state_dbg)
  );

  // Clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous RAM: read data one clock after ramR, write on ramW
  always @(posedge clock) begin
    if (pl_en) mem[pl_idx] <= pl_val;
    if (ramR) ramDataR <= mem[ramAddr[4:0]];
    if (ramW) begin
      mem[ramAddr[4:0]] <= ramDataW;
      wr_count <= wr_count + 1;
    end
  end

  task automatic set_word(input logic [4:0] idx, input logic [31:0] val);
    @(negedge clock);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    @(negedge clock);
    pl_en = 1'b0;
  endtask

  // Drive one request; report completion cycle, err, RAM activity.
  task automatic run_op(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output int lat, output logic e,
                        output int nr, output int nw, output int rc, output int wc,
                        output logic [31:0] last_addr);
    lat = 0; e = 1'b0; nr = 0; nw = 0; rc = 0; wc = 0; last_addr = 32'hFFFF_FFFF;
    @(negedge clock);
    req = 1'b1; we = w; funct3 = f3; addr = a; wdata = wd;
    @(negedge clock);
    req = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (ramR) begin nr++; if (rc == 0) rc = c; last_addr = ramAddr; end
      if (ramW) begin nw++; if (wc == 0) wc = c; last_addr = ramAddr; end
      if (done) begin lat = c; e = err; break; end
      @(negedge clock);
    end
  endtask

  task automatic test_reset;
    nReset = 1'b0;
    repeat (2) @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_done_err got %b%b want 00", done, err); end
    checks++; if (ramR !== 1'b0 || ramW !== 1'b0) begin errors++; $display("FAIL reset_ram_strobes got %b%b want 00", ramR, ramW); end
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata); end
    checks++; if (ramAddr !== 32'd0 || ramDataW !== 32'd0) begin errors++; $display("FAIL reset_ram_bus got %h/%h want 0/0", ramAddr, ramDataW); end
    nReset = 1'b1;
  endtask

  task automatic test_load_word;
    int lat, nr, nw, rc, wc; logic e; logic [31:0] la;
    set_word(5'd2, 32'h8899AABB);
    run_op(1'b0, 3'b010, 32'h8, 32'h0, lat, e, nr, nw, rc, wc, la);
    checks++; if (lat !== 3) begin errors++; $display("FAIL lw_latency got %0d want 3", lat); end
    checks++; if (rc !== 1 || nr !== 1) begin errors++; $display("FAIL lw_ramR got cycle %0d count %0d want 1/1", rc, nr); end
    checks++; if (la !== 32'd2) begin errors++; $display("FAIL lw_ramAddr got %h want 2", la); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL lw_err got %b want 0", e); end
    checks++; if (rdata !== 32'h8899AABB) begin errors++; $display("FAIL lw_rdata got %h want 8899aabb", rdata); end
  endtask

  task automatic test_load_lanes;
    logic [2:0]  f3s [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000};
    logic [31:0] as  [5] = '{32'h9, 32'h9, 32'hA, 32'hA, 32'h8};
    logic [31:0] exp [5] = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899, 32'h00008899, 32'hFFFFFFBB};
    int lat, nr, nw, rc, wc; logic e; logic [31:0] la;
    for (int i = 0; i < 5; i++) begin
      run_op(1'b0, f3s[i], as[i], 32'h0, lat, e, nr, nw, rc, wc, la);
      checks++; if (rdata !== exp[i] || lat !== 3) begin
        errors++; $display("FAIL lane_load%0d got %h lat %0d want %h lat 3", i, rdata, lat, exp[i]);
      end
    end
  endtask

  task automatic test_sub_store;
    int lat, nr, nw, rc, wc; logic e; logic [31:0] la;
    run_op(1'b1, 3'b000, 32'hB, 32'h12345677, lat, e, nr, nw, rc, wc, la);
    checks++; if (lat !== 4) begin errors++; $display("FAIL sb_latency got %0d want 4", lat); end
    checks++; if (nr !== 1 || rc !== 1 || nw !== 1 || wc !== 3) begin
      errors++; $display("FAIL sb_sequence got r%0d@%0d w%0d@%0d want r1@1 w1@3", nr, rc, nw, wc); end
    checks++; if (la !== 32'd2) begin errors++; $display("FAIL sb_ramAddr got %h want 2", la); end
    checks++; if (mem[2] !== 32'h7799AABB) begin errors++; $display("FAIL sb_word got %h want 7799aabb", mem[2]); end
    checks++; if (rdata !== 32'hFFFFFFBB) begin errors++; $display("FAIL sb_rdata_kept got %h want ffffffbb", rdata); end
    run_op(1'b1, 3'b001, 32'h8, 32'h0000CAFE, lat, e, nr, nw, rc, wc, la);
    checks++; if (mem[2] !== 32'h7799CAFE || lat !== 4) begin
      errors++; $display("FAIL sh_word got %h lat %0d want 7799cafe lat 4", mem[2], lat); end
    // Full word store, then read back through an aliased address (0x90 -> word 4)
    run_op(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, lat, e, nr, nw, rc, wc, la);
    checks++; if (lat !== 2 || nr !== 0 || nw !== 1 || mem[4] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL sw got lat %0d r%0d w%0d word %h want lat 2 r0 w1 deadbeef", lat, nr, nw, mem[4]); end
    run_op(1'b0, 3'b010, 32'h90, 32'h0, lat, e, nr, nw, rc, wc, la);
    checks++; if (rdata !== 32'hDEADBEEF || la !== 32'd4) begin
      errors++; $display("FAIL alias_load got %h addr %h want deadbeef addr 4", rdata, la); end
  endtask

  task automatic test_errors;
    logic        ws  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]  f3s [4] = '{3'b010, 3'b001, 3'b011, 3'b100};
    logic [31:0] as  [4] = '{32'h6, 32'h5, 32'h8, 32'h8};
    int lat, nr, nw, rc, wc; logic e; logic [31:0] la;
    logic [31:0] word_before;
    for (int i = 0; i < 4; i++) begin
      word_before = mem[2];
      run_op(ws[i], f3s[i], as[i], 32'h55555555, lat, e, nr, nw, rc, wc, la);
      checks++; if (lat !== 1 || e !== 1'b1) begin
        errors++; $display("FAIL err%0d_pulse got lat %0d err %b want lat 1 err 1", i, lat, e); end
      checks++; if (nr !== 0 || nw !== 0 || rdata !== 32'hDEADBEEF || mem[2] !== word_before) begin
        errors++; $display("FAIL err%0d_side_effect got r%0d w%0d rdata %h want r0 w0 deadbeef", i, nr, nw, rdata); end
    end
  endtask

  task automatic test_back_to_back;
    int first_done, second_done, writes;
    first_done = 0; second_done = 0; writes = 0;
    set_word(5'd5, 32'h11223344);
    @(negedge clock);
    req = 1'b1; we = 1'b1; funct3 = 3'b000; addr = 32'h14; wdata = 32'h000000AA;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clock);
      if (c == 1) begin we = 1'b0; funct3 = 3'b010; end
      if (c == 6) req = 1'b0;
      if (ramW) writes++;
      if (done) begin
        if (first_done == 0) first_done = c;
        else if (second_done == 0) second_done = c;
      end
    end
    checks++; if (first_done !== 4 || writes !== 1) begin
      errors++; $display("FAIL b2b_first got done@%0d writes %0d want done@4 writes 1", first_done, writes); end
    checks++; if (second_done !== 8) begin
      errors++; $display("FAIL b2b_second got done@%0d want done@8", second_done); end
    checks++; if (rdata !== 32'h112233AA || mem[5] !== 32'h112233AA) begin
      errors++; $display("FAIL b2b_data got rdata %h word %h want 112233aa", rdata, mem[5]); end
  endtask

  task automatic test_reset_mid;
    int lat, nr, nw, rc, wc, w0; logic e; logic [31:0] la;
    set_word(5'd6, 32'h55667788);
    w0 = wr_count;
    @(negedge clock);
    req = 1'b1; we = 1'b1; funct3 = 3'b000; addr = 32'h18; wdata = 32'h99;
    @(negedge clock);
    req = 1'b0;
    @(negedge clock);
    checks++; if (state_dbg !== 3'd3 || busy !== 1'b1) begin
      errors++; $display("FAIL mid_in_merge got state %0d busy %b want 3/1", state_dbg, busy); end
    #2 nReset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || ramR !== 1'b0 || ramW !== 1'b0 || ramDataW !== 32'd0 || ramAddr !== 32'd0) begin
      errors++; $display("FAIL mid_async_clear got busy %b done %b r %b w %b dw %h a %h want all 0",
                          busy, done, ramR, ramW, ramDataW, ramAddr); end
    repeat (3) @(negedge clock);
    nReset = 1'b1;
    repeat (2) @(negedge clock);
    checks++; if (wr_count !== w0 || mem[6] !== 32'h55667788) begin
      errors++; $display("FAIL mid_no_write got writes %0d word %h want 0 55667788", wr_count - w0, mem[6]); end
    run_op(1'b0, 3'b010, 32'h18, 32'h0, lat, e, nr, nw, rc, wc, la);
    checks++; if (rdata !== 32'h55667788 || lat !== 3) begin
      errors++; $display("FAIL mid_reload got %h lat %0d want 55667788 lat 3", rdata, lat); end
  endtask

  initial begin
    nReset = 1'b0; req = 1'b0; we = 1'b0; funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
    pl_en = 1'b0; pl_idx = 5'd0; pl_val = 32'h0; ramDataR = 32'h0;
    test_reset();
    test_load_word();
    test_load_lanes();
    test_sub_store();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound on the whole run
  initial begin
    #200000;
    $display("FAIL timeout reached at %0t", $time);
    $fatal(1);
  end

endmodule
